// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg
// Shared definitions for the graph-traversal core memory arbiter:
//   WORD_W     - memory data word width
//   REQ_*      - requester index constants (ifetch, load/store, frontier)
//   OWNER_W    - width of a requester/owner id for the default three requesters
//   wrap_inc() - modular increment used for the round-robin pointer
package mem_arbiter_pkg;

    localparam int WORD_W     = 16;

    localparam int REQ_IFETCH = 0;
    localparam int REQ_LDST   = 1;
    localparam int REQ_FRONT  = 2;

    localparam int N_REQ_DEF  = 3;
    localparam int OWNER_W    = 2;

    // Returns (idx + 1) mod n, for idx in [0, n-1].
    function automatic int wrap_inc(input int idx, input int n);
        int nxt;
        nxt = idx + 1;
        if (nxt >= n) begin
            nxt = 0;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/mem_arbiter_rr_pick.sv
// rr_pick
// Combinational rotating-priority picker. Scans the request vector starting
// at i_start and wrapping from N-1 to 0; the first set bit wins.
// Ports:
//   i_req    [N-1:0]     request vector
//   i_start  [IDX_W-1:0] index with highest priority (must be < N)
//   o_onehot [N-1:0]     one-hot winner, 0 when no request
//   o_idx    [IDX_W-1:0] winner index, 0 when no request
//   o_valid              at least one request present
module rr_pick #(
    parameter int N     = 3,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     i_req,
    input  logic [IDX_W-1:0] i_start,
    output logic [N-1:0]     o_onehot,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_valid
);

    always_comb begin
        int         j;
        logic [N-1:0] w_rot;
        o_onehot = '0;
        o_idx    = '0;
        o_valid  = 1'b0;
        j        = 0;
        w_rot    = '0;
        for (int k = 0; k < N; k++) begin
            j = int'(i_start) + k;
            if (j >= N) begin
                j = j - N;
            end
            w_rot = i_req >> j;
            if (!o_valid && w_rot[0]) begin
                o_valid  = 1'b1;
                o_onehot = N'(1) << j;
                o_idx    = IDX_W'(j);
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter
// Shared-memory arbiter and response router. Grants at most one of N_REQ
// requesters per cycle (round-robin with bounded lock bursts), drives the
// single-port pipelined memory, and routes read data back to its owner
// MEM_LAT cycles after the access.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   req/we/lock [N_REQ] per-requester request, write enable, keep-grant
//   addr  [N_REQ*ADDR_W] packed addresses, requester i at [i*ADDR_W +: ADDR_W]
//   wdata [N_REQ*DATA_W] packed write data
//   gnt    [N_REQ]      one-hot combinational grant
//   rvalid [N_REQ]      one-hot read-data valid for the owner
//   rdata  [DATA_W]     read data, qualified by rvalid
//   mem_en/mem_we/mem_addr/mem_wdata  memory request bus
//   mem_rdata [DATA_W]  memory read data, valid MEM_LAT cycles after a read
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int N_REQ    = N_REQ_DEF,
    parameter int ADDR_W   = 16,
    parameter int MEM_LAT  = 2,
    parameter int LOCK_MAX = 4,
    parameter int DATA_W   = WORD_W
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [N_REQ-1:0]        req,
    input  logic [N_REQ-1:0]        we,
    input  logic [N_REQ-1:0]        lock,
    input  logic [N_REQ*ADDR_W-1:0] addr,
    input  logic [N_REQ*DATA_W-1:0] wdata,
    output logic [N_REQ-1:0]        gnt,
    output logic [N_REQ-1:0]        rvalid,
    output logic [DATA_W-1:0]       rdata,
    output logic                    mem_en,
    output logic                    mem_we,
    output logic [ADDR_W-1:0]       mem_addr,
    output logic [DATA_W-1:0]       mem_wdata,
    input  logic [DATA_W-1:0]       mem_rdata
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CNT_W = $clog2(LOCK_MAX + 1);

    // Arbitration state
    logic [IDX_W-1:0]  r_rr_ptr;
    logic              r_lock_vld;
    logic [IDX_W-1:0]  r_lock_own;
    logic [CNT_W-1:0]  r_lock_cnt;

    // Last issued memory request, held on the bus while idle
    logic              r_last_we;
    logic [ADDR_W-1:0] r_last_addr;
    logic [DATA_W-1:0] r_last_wdata;

    // Response pipeline: slot 0 is filled in the grant cycle, slot MEM_LAT-1
    // lines up with mem_rdata.
    logic              r_rsp_vld [MEM_LAT];
    logic [IDX_W-1:0]  r_rsp_own [MEM_LAT];

    logic [N_REQ-1:0]  w_pick_oh;
    logic [IDX_W-1:0]  w_pick_idx;
    logic              w_pick_vld;
    logic              w_lock_hit;
    logic              w_any;
    logic [IDX_W-1:0]  w_win_idx;
    logic [N_REQ-1:0]  w_win_oh;
    logic              w_win_we;
    logic              w_win_lock;
    logic [ADDR_W-1:0] w_win_addr;
    logic [DATA_W-1:0] w_win_wdata;

    rr_pick #(
        .N     (N_REQ),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .i_req    (req),
        .i_start  (r_rr_ptr),
        .o_onehot (w_pick_oh),
        .o_idx    (w_pick_idx),
        .o_valid  (w_pick_vld)
    );

    // The locked owner keeps the grant while it still requests and has not
    // used up its burst; once the burst is spent, r_rr_ptr already points
    // just after it, so normal round-robin resumes after the owner.
    assign w_lock_hit = r_lock_vld && req[r_lock_own] &&
                        (r_lock_cnt < CNT_W'(LOCK_MAX));

    // Gating with rst_n keeps every combinational output at 0 during reset.
    assign w_any      = rst_n && w_pick_vld;

    assign w_win_idx  = w_lock_hit ? r_lock_own : w_pick_idx;
    assign w_win_oh   = w_lock_hit ? (N_REQ'(1) << r_lock_own) : w_pick_oh;
    assign w_win_we   = we[w_win_idx];
    assign w_win_lock = lock[w_win_idx];
    assign w_win_addr = addr[w_win_idx*ADDR_W +: ADDR_W];
    assign w_win_wdata = wdata[w_win_idx*DATA_W +: DATA_W];

    assign gnt       = w_any ? w_win_oh    : '0;
    assign mem_en    = w_any;
    assign mem_we    = w_any ? w_win_we    : r_last_we;
    assign mem_addr  = w_any ? w_win_addr  : r_last_addr;
    assign mem_wdata = w_any ? w_win_wdata : r_last_wdata;

    // Read data is not re-registered: it is passed through in the cycle the
    // registered tail slot says it belongs to an owner.
    assign rvalid = r_rsp_vld[MEM_LAT-1] ? (N_REQ'(1) << r_rsp_own[MEM_LAT-1]) : '0;
    assign rdata  = r_rsp_vld[MEM_LAT-1] ? mem_rdata : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_ptr     <= '0;
            r_lock_vld   <= 1'b0;
            r_lock_own   <= '0;
            r_lock_cnt   <= '0;
            r_last_we    <= 1'b0;
            r_last_addr  <= '0;
            r_last_wdata <= '0;
            for (int k = 0; k < MEM_LAT; k++) begin
                r_rsp_vld[k] <= 1'b0;
                r_rsp_own[k] <= '0;
            end
        end else begin
            if (w_any) begin
                r_rr_ptr     <= IDX_W'(wrap_inc(int'(w_win_idx), N_REQ));
                r_last_we    <= w_win_we;
                r_last_addr  <= w_win_addr;
                r_last_wdata <= w_win_wdata;
                if (w_win_lock) begin
                    // A grant won through round-robin starts a fresh burst.
                    r_lock_vld <= 1'b1;
                    r_lock_own <= w_win_idx;
                    r_lock_cnt <= w_lock_hit ? (r_lock_cnt + CNT_W'(1)) : CNT_W'(1);
                end else begin
                    r_lock_vld <= 1'b0;
                    r_lock_cnt <= '0;
                end
            end else begin
                r_lock_vld <= 1'b0;
                r_lock_cnt <= '0;
            end

            r_rsp_vld[0] <= w_any && !w_win_we;
            r_rsp_own[0] <= w_win_idx;
            for (int k = 1; k < MEM_LAT; k++) begin
                r_rsp_vld[k] <= r_rsp_vld[k-1];
                r_rsp_own[k] <= r_rsp_own[k-1];
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
// Directed bench for mem_arbiter with a two-cycle-latency memory model.
module tb_mem_arbiter;

    logic        clk;
    logic        rst_n;
    logic [2:0]  req;
    logic [2:0]  we;
    logic [2:0]  lock;
    logic [47:0] addr;
    logic [47:0] wdata;
    logic [2:0]  gnt;
    logic [2:0]  rvalid;
    logic [15:0] rdata;
    logic        mem_en;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;

    logic [15:0] rd_p0;
    logic [15:0] rd_p1;

    int n_vec  = 0;
    int n_miss = 0;

    mem_arbiter #(
        .N_REQ    (3),
        .ADDR_W   (16),
        .MEM_LAT  (2),
        .LOCK_MAX (4),
        .DATA_W   (16)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .we        (we),
        .lock      (lock),
        .addr      (addr),
        .wdata     (wdata),
        .gnt       (gnt),
        .rvalid    (rvalid),
        .rdata     (rdata),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory contents for the addresses the bench reads.
    function automatic logic [15:0] mem_fn(input logic [15:0] a);
        case (a)
            16'h0010: return 16'hBEEF;
            16'h0100: return 16'h1111;
            16'h0200: return 16'h2222;
            16'h0300: return 16'h3333;
            default:  return 16'hDEAD;
        endcase
    endfunction

    always @(posedge clk) begin
        rd_p0 <= (mem_en && !mem_we) ? mem_fn(mem_addr) : 16'h0000;
        rd_p1 <= rd_p0;
    end
    assign mem_rdata = rd_p1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_addr(input int i, input logic [15:0] a);
        addr[i*16 +: 16] = a;
    endtask

    task automatic set_wdata(input int i, input logic [15:0] d);
        wdata[i*16 +: 16] = d;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    logic [2:0] eg;
    logic [2:0] lock_seq [6];

    initial begin
        rd_p0 = 16'h0;
        rd_p1 = 16'h0;
        rst_n = 1'b0;
        req   = 3'b111;
        we    = 3'b000;
        lock  = 3'b000;
        addr  = '0;
        wdata = '0;

        // Reset with requests pending: everything must stay at 0.
        next_cycle();
        next_cycle();
        @(negedge clk);
        chk("rst_gnt",       32'(gnt),       32'h0);
        chk("rst_rvalid",    32'(rvalid),    32'h0);
        chk("rst_rdata",     32'(rdata),     32'h0);
        chk("rst_mem_en",    32'(mem_en),    32'h0);
        chk("rst_mem_we",    32'(mem_we),    32'h0);
        chk("rst_mem_addr",  32'(mem_addr),  32'h0);
        chk("rst_mem_wdata", 32'(mem_wdata), 32'h0);

        // Plain round-robin with all three requesting (writes).
        next_cycle();
        rst_n = 1'b1;
        req   = 3'b111;
        we    = 3'b111;
        for (int i = 0; i < 3; i++) begin
            set_addr(i, 16'h0A00 + 16'(i));
            set_wdata(i, 16'h00A0 + 16'(i));
        end
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            eg = 3'b001 << (i % 3);
            chk("rr_gnt",  32'(gnt),      32'(eg));
            chk("rr_addr", 32'(mem_addr), 32'(16'h0A00 + 16'(i % 3)));
            next_cycle();
        end

        // Idle: no grant, bus holds the last winner (requester 2).
        req = 3'b000;
        @(negedge clk);
        chk("idle_gnt",   32'(gnt),       32'h0);
        chk("idle_en",    32'(mem_en),    32'h0);
        chk("idle_addr",  32'(mem_addr),  32'h0A02);
        chk("idle_we",    32'(mem_we),    32'h1);
        chk("idle_wdata", 32'(mem_wdata), 32'h00A2);
        next_cycle();

        // Requester 1 reads 0x0010; data returns exactly two cycles later.
        req = 3'b010;
        we  = 3'b000;
        set_addr(1, 16'h0010);
        @(negedge clk);
        chk("rd_gnt",  32'(gnt),      32'h2);
        chk("rd_en",   32'(mem_en),   32'h1);
        chk("rd_we",   32'(mem_we),   32'h0);
        chk("rd_addr", 32'(mem_addr), 32'h0010);
        next_cycle();
        req = 3'b000;
        @(negedge clk);
        chk("rd_t1_rvalid", 32'(rvalid), 32'h0);
        next_cycle();
        @(negedge clk);
        chk("rd_t2_rvalid", 32'(rvalid), 32'h2);
        chk("rd_t2_rdata",  32'(rdata),  32'hBEEF);
        next_cycle();

        // Requester 2 locked against requester 0: burst of 4, then 0, then 2.
        req  = 3'b101;
        we   = 3'b101;
        lock = 3'b100;
        lock_seq = '{3'b100, 3'b100, 3'b100, 3'b100, 3'b001, 3'b100};
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("lock_gnt", 32'(gnt), 32'(lock_seq[i]));
            next_cycle();
        end

        // Requester 1 write: no response afterwards; lock without req ignored.
        req  = 3'b010;
        we   = 3'b010;
        lock = 3'b000;
        set_addr(1, 16'h0020);
        set_wdata(1, 16'h1234);
        @(negedge clk);
        chk("wr_gnt",   32'(gnt),       32'h2);
        chk("wr_we",    32'(mem_we),    32'h1);
        chk("wr_addr",  32'(mem_addr),  32'h0020);
        chk("wr_wdata", 32'(mem_wdata), 32'h1234);
        next_cycle();
        req  = 3'b000;
        lock = 3'b001;
        @(negedge clk);
        chk("wr_t1_rvalid", 32'(rvalid), 32'h0);
        chk("lock_noreq_gnt", 32'(gnt), 32'h0);
        chk("lock_noreq_en",  32'(mem_en), 32'h0);
        next_cycle();
        @(negedge clk);
        chk("wr_t2_rvalid", 32'(rvalid), 32'h0);
        next_cycle();
        lock = 3'b000;

        // Back-to-back reads by 0, 1, 2 return in issue order.
        we = 3'b000;
        set_addr(0, 16'h0100);
        set_addr(1, 16'h0200);
        set_addr(2, 16'h0300);
        req = 3'b001;
        @(negedge clk);
        chk("il_gnt0", 32'(gnt), 32'h1);
        next_cycle();
        req = 3'b010;
        @(negedge clk);
        chk("il_gnt1", 32'(gnt), 32'h2);
        next_cycle();
        req = 3'b100;
        @(negedge clk);
        chk("il_gnt2",   32'(gnt),    32'h4);
        chk("il_rv0",    32'(rvalid), 32'h1);
        chk("il_rdata0", 32'(rdata),  32'h1111);
        next_cycle();
        req = 3'b000;
        @(negedge clk);
        chk("il_rv1",    32'(rvalid), 32'h2);
        chk("il_rdata1", 32'(rdata),  32'h2222);
        next_cycle();
        @(negedge clk);
        chk("il_rv2",    32'(rvalid), 32'h4);
        chk("il_rdata2", 32'(rdata),  32'h3333);
        next_cycle();
        @(negedge clk);
        chk("il_rv_end", 32'(rvalid), 32'h0);
        next_cycle();

        // Reset one cycle after a read grant drops the read.
        req = 3'b010;
        set_addr(1, 16'h0010);
        @(negedge clk);
        chk("mr_gnt", 32'(gnt), 32'h2);
        next_cycle();
        rst_n = 1'b0;
        req   = 3'b111;
        @(negedge clk);
        chk("mr_rst_gnt",   32'(gnt),       32'h0);
        chk("mr_rst_rv",    32'(rvalid),    32'h0);
        chk("mr_rst_en",    32'(mem_en),    32'h0);
        chk("mr_rst_addr",  32'(mem_addr),  32'h0);
        chk("mr_rst_we",    32'(mem_we),    32'h0);
        chk("mr_rst_wdata", 32'(mem_wdata), 32'h0);
        next_cycle();
        @(negedge clk);
        chk("mr_t2_rv",    32'(rvalid), 32'h0);
        chk("mr_t2_rdata", 32'(rdata),  32'h0);
        next_cycle();
        rst_n = 1'b1;
        we    = 3'b111;
        @(negedge clk);
        chk("mr_rel_gnt", 32'(gnt),    32'h1);
        chk("mr_rel_rv",  32'(rvalid), 32'h0);
        next_cycle();
        @(negedge clk);
        chk("mr_rel_gnt2", 32'(gnt),    32'h2);
        chk("mr_rel_rv2",  32'(rvalid), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
